// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - shared types and helpers for the Genius round sequencer.
package genius_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHOW_FETCH,
    SHOW_ON,
    SHOW_OFF,
    IN_FETCH,
    IN_WAIT,
    IN_RELEASE
  } state_t;

  localparam logic FAIL_WRONG   = 1'b0;
  localparam logic FAIL_TIMEOUT = 1'b1;

  // Symbol 3 maps to no button, so it can never be matched.
  function automatic logic [2:0] sym_to_btn(input logic [1:0] sym);
    case (sym)
      2'd0:    sym_to_btn = 3'b001;
      2'd1:    sym_to_btn = 3'b010;
      2'd2:    sym_to_btn = 3'b100;
      default: sym_to_btn = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/press_detect.sv
// rtl/press_detect.sv - rising press detection and expected-symbol match.
module press_detect
  import genius_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] btn,
  input  logic [1:0] expected,
  output logic       press_evt,
  output logic       onehot,
  output logic       match
);

  logic [2:0] prev_q, prev_d;

  always_comb begin
    prev_d = btn;
  end

  always_ff @(posedge clock) begin
    if (reset) prev_q <= 3'b000;
    else       prev_q <= prev_d;
  end

  // Only an all-released to something-pressed transition counts as a press.
  assign press_evt = (btn != 3'b000) && (prev_q == 3'b000);
  assign onehot    = (btn != 3'b000) && ((btn & (btn - 3'd1)) == 3'b000);
  assign match     = (btn == sym_to_btn(expected));

endmodule

// File: rtl/genius_round_ctrl.sv
// rtl/genius_round_ctrl.sv - per-round show/receive sequencer for the Genius game.
module genius_round_ctrl
  import genius_pkg::*;
#(
  parameter int unsigned ON_CYCLES      = 25_000_000,
  parameter int unsigned OFF_CYCLES     = 12_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned SYM_LAT        = 1,
  parameter int unsigned CNT_W          = 27
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       round_go,
  input  logic [3:0] round_len,
  input  logic [1:0] symbol,
  input  logic [2:0] btn,
  output logic [3:0] seq_index,
  output logic       show_valid,
  output logic [1:0] show_symbol,
  output logic       input_window,
  output logic       press_ok,
  output logic       round_pass,
  output logic       round_fail,
  output logic       fail_code,
  output logic       busy
);

  localparam logic [CNT_W-1:0] FETCH_LOAD = CNT_W'(SYM_LAT);
  localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD   = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD    = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       len_q, len_d;
  logic [3:0]       idx_q, idx_d;
  logic [1:0]       exp_q, exp_d;
  logic [1:0]       show_sym_q, show_sym_d;
  logic             show_valid_q, show_valid_d;
  logic             window_q, window_d;
  logic             press_ok_q, press_ok_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             fail_code_q, fail_code_d;
  logic             busy_q, busy_d;

  logic press_evt, onehot, match, cnt_done, last_idx;

  press_detect u_press_detect (
    .clock     (clock),
    .reset     (reset),
    .btn       (btn),
    .expected  (exp_q),
    .press_evt (press_evt),
    .onehot    (onehot),
    .match     (match)
  );

  assign cnt_done = (cnt_q == '0);
  assign last_idx = (idx_q == len_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    idx_d        = idx_q;
    exp_d        = exp_q;
    show_sym_d   = show_sym_q;
    show_valid_d = show_valid_q;
    window_d     = window_q;
    fail_code_d  = fail_code_q;
    press_ok_d   = 1'b0;
    pass_d       = 1'b0;
    fail_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (round_go) begin
          len_d       = round_len;
          idx_d       = 4'd0;
          fail_code_d = FAIL_WRONG;
          cnt_d       = FETCH_LOAD;
          state_d     = SHOW_FETCH;
        end
      end
      SHOW_FETCH: begin
        if (cnt_done) begin
          show_sym_d   = symbol;
          show_valid_d = 1'b1;
          cnt_d        = ON_LOAD;
          state_d      = SHOW_ON;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SHOW_ON: begin
        if (cnt_done) begin
          show_valid_d = 1'b0;
          cnt_d        = OFF_LOAD;
          state_d      = SHOW_OFF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SHOW_OFF: begin
        if (cnt_done) begin
          cnt_d = FETCH_LOAD;
          if (last_idx) begin
            idx_d   = 4'd0;
            state_d = IN_FETCH;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = SHOW_FETCH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      IN_FETCH: begin
        if (cnt_done) begin
          exp_d    = symbol;
          window_d = 1'b1;
          cnt_d    = TO_LOAD;
          state_d  = IN_WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      IN_WAIT: begin
        // A press in the expiry cycle still decides the outcome.
        if (press_evt) begin
          window_d = 1'b0;
          if (onehot && match) begin
            press_ok_d = 1'b1;
            state_d    = IN_RELEASE;
          end else begin
            fail_d      = 1'b1;
            fail_code_d = FAIL_WRONG;
            state_d     = IDLE;
          end
        end else if (cnt_done) begin
          window_d    = 1'b0;
          fail_d      = 1'b1;
          fail_code_d = FAIL_TIMEOUT;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      IN_RELEASE: begin
        if (btn == 3'b000) begin
          if (last_idx) begin
            pass_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            cnt_d   = FETCH_LOAD;
            state_d = IN_FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= 4'd0;
      idx_q        <= 4'd0;
      exp_q        <= 2'd0;
      show_sym_q   <= 2'd0;
      show_valid_q <= 1'b0;
      window_q     <= 1'b0;
      press_ok_q   <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_code_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      exp_q        <= exp_d;
      show_sym_q   <= show_sym_d;
      show_valid_q <= show_valid_d;
      window_q     <= window_d;
      press_ok_q   <= press_ok_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      fail_code_q  <= fail_code_d;
      busy_q       <= busy_d;
    end
  end

  assign seq_index    = idx_q;
  assign show_valid   = show_valid_q;
  assign show_symbol  = show_sym_q;
  assign input_window = window_q;
  assign press_ok     = press_ok_q;
  assign round_pass   = pass_q;
  assign round_fail   = fail_q;
  assign fail_code    = fail_code_q;
  assign busy         = busy_q;

endmodule
